cs_y_stream_buffer: RTL
=======================

// Module: cs_y_stream_buffer
// PURPOSE
//  Downstream stage of the CS approximate-average core. It consumes the free-running 10-bit Y stream,
//  one word per clk, and discards the warm-up words CS emits before its 9-sample window is full.
//  Valid words are queued in a show-ahead FIFO and handed to the consumer (output writer or packer)
//  over a valid/ready handshake. Overflow is tracked rather than stalling CS, which cannot be back-pressured.
// PARAMETERS
//  WARMUP  8   clk edges after reset/clr whose Y is discarded (CS window fill)
//  DEPTH   16  FIFO entries; power of 2, >= 2
//  DW      10  data width (matches CS Y)
// PORTS
//  clk        in   1               rising-edge clock (same clk as CS)
//  reset      in   1               asynchronous, active-high reset
//  clr        in   1               synchronous flush: empties FIFO, clears flags, restarts warm-up
//  y_in       in   DW              CS Y output; sampled every rising edge
//  out_data   out  DW              FIFO head word; valid only when out_valid=1
//  out_valid  out  1               head word present
//  out_ready  in   1               consumer accepts head this edge
//  level      out  $clog2(DEPTH)+1 current FIFO occupancy, 0..DEPTH
//  overflow   out  1               sticky: a valid Y word was dropped
//  drop_cnt   out  8               count of dropped words; saturates at 255
// BEHAVIOUR
//  Reset (async, reset=1): state=WARM; warm_cnt=0; FIFO empty. Outputs: out_valid=0, out_data=0,
//    level=0, overflow=0, drop_cnt=0.
//  FSM
//    WARM: each edge warm_cnt++. Nothing is pushed. When warm_cnt==WARMUP-1 at an edge -> STREAM.
//      The y_in sampled on that edge is discarded, so exactly WARMUP words are discarded.
//    STREAM: every edge is a push request of y_in. The FSM stays in STREAM until reset or clr.
//  Pop = out_valid & out_ready. A pop removes the head at that edge.
//  Push is accepted if level<DEPTH, or if level==DEPTH and a pop occurs on the same edge.
//    On a simultaneous push and pop, level is unchanged.
//  Push when level==DEPTH with no pop: the word is dropped and the FIFO is unchanged.
//    overflow<=1; drop_cnt<=drop_cnt+1, saturating at 255.
//  Latency: a word pushed at edge t into an empty FIFO gives out_valid=1 with out_data=that word
//    after edge t (one-cycle latency). There is no combinational path from y_in to out_data.
//  out_data holds the head value while out_valid=1 and no pop occurs. out_data=0 whenever level==0.
//  Ordering is strict FIFO; pointers wrap modulo DEPTH and an extra wrap bit distinguishes full from empty.
//  level is registered and is always consistent with out_valid (out_valid == (level!=0)).
//  clr=1 at an edge has priority over push/pop on that edge.
//    Effect: FIFO empty, level=0, out_valid=0, overflow=0, drop_cnt=0, state=WARM, warm_cnt=0.
//    The y_in on the clr edge is discarded and is not counted as a warm-up edge.
//  Reset mid-stream: all state clears immediately (async); the warm-up restarts after deassert.
//  out_ready while out_valid=0 is ignored. No underflow is possible.
// TESTING
//  T1 warm-up: reset, then y_in = edge index 0,1,2,... with out_ready=1.
//     -> words 0..7 dropped; first out_data=8 one cycle after edge 8; then 9,10,... each cycle.
//  T2 fill/overflow: out_ready=0 for 20 STREAM edges, DEPTH=16.
//     -> level=16; overflow=1; drop_cnt=4. Then drain with out_ready=1 -> the first 16 words in order.
//  T3 full + simultaneous pop: level=16, out_ready=1 for one edge with a new y_in=0x3FF.
//     -> level stays 16; no drop; 0x3FF is last in order.
//  T4 drop_cnt saturation: out_ready=0 for 300 STREAM edges -> drop_cnt=255, overflow=1.
//  T5 clr mid-stream: level=5, overflow=1, pulse clr.
//     -> next cycle level=0, out_valid=0, overflow=0; 8 words discarded again before the next push.
//  T6 async reset mid-operation: assert reset between edges.
//     -> out_valid=0 and level=0 at once, without waiting for a clk edge; stream resumes after WARMUP edges.

Source files
------------

// File: rtl/cs_y_stream_buffer_if.sv
// Output stream of the CS Y buffer: show-ahead head word with a valid/ready handshake.
interface cs_y_stream_buffer_if #(
    parameter int DW = 10
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/cs_y_stream_buffer.sv
// Drops the CS warm-up words, then queues every Y word in a show-ahead FIFO.
// Overflow drops the incoming word and is counted, since CS cannot be stalled.
module cs_y_stream_buffer #(
    parameter int WARMUP = 8,
    parameter int DEPTH  = 16,
    parameter int DW     = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic [DW-1:0]            y_in,
    cs_y_stream_buffer_if.master     out_if,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = $clog2(WARMUP + 1);

    typedef enum logic {WARM, STREAM} state_t;

    state_t          state_reg, state_next;
    logic [WW-1:0]   warm_cnt_reg, warm_cnt_next;

    logic [DW-1:0]   mem [DEPTH];
    logic [AW:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
    logic [LW-1:0]   level_reg;
    logic [DW-1:0]   out_data_reg;
    logic            overflow_reg;
    logic [7:0]      drop_cnt_reg;

    logic            out_valid, pop, push_req, full, push_ok, drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= WARM;
            warm_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            warm_cnt_reg <= warm_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        warm_cnt_next = warm_cnt_reg;
        if (clr) begin
            state_next    = WARM;
            warm_cnt_next = '0;
        end else begin
            case (state_reg)
                WARM: begin
                    if (warm_cnt_reg == WW'(WARMUP - 1)) begin
                        state_next    = STREAM;
                        warm_cnt_next = '0;
                    end else begin
                        warm_cnt_next = warm_cnt_reg + 1'b1;
                    end
                end
                default: state_next = STREAM;
            endcase
        end
    end

    assign out_valid  = (level_reg != '0);
    assign pop        = out_valid & out_if.out_ready;
    assign push_req   = (state_reg == STREAM);
    assign full       = (level_reg == LW'(DEPTH));
    assign push_ok    = push_req & (~full | pop);
    assign drop       = push_req & full & ~pop;
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok && !clr)
            mem[wr_ptr_reg[AW-1:0]] <= y_in;
    end

    // out_data is a register holding the head that will be visible after this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            out_data_reg <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (clr) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            out_data_reg <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_inc;

            if (push_ok && !pop)
                level_reg <= level_reg + 1'b1;
            else if (pop && !push_ok)
                level_reg <= level_reg - 1'b1;

            if (pop) begin
                if (level_reg == LW'(1))
                    out_data_reg <= push_ok ? y_in : '0;
                else
                    out_data_reg <= mem[rd_ptr_inc[AW-1:0]];
            end else if (!out_valid && push_ok) begin
                out_data_reg <= y_in;
            end

            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_cnt_reg != 8'hFF)
                    drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
        end
    end

    assign out_if.out_data  = out_data_reg;
    assign out_if.out_valid = out_valid;
    assign level            = level_reg;
    assign overflow         = overflow_reg;
    assign drop_cnt         = drop_cnt_reg;
endmodule
